// File: rtl/cgra_cfg_rf.sv
// CGRA-side configuration register file: per-channel write/read decode, fixed-latency f2g read-back.
// Define CGRA_CFG_RF_BCAST_EN to make an all-ones tile id write every tile of the issuing channel.
module cgra_cfg_rf_tile #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 8,
    parameter int RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [REG_ADDR_WIDTH-1:0] ridx,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid
);
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]               regs [NUM_REGS];
    logic [RD_LATENCY:1]                 vld_pipe;
    logic [RD_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wr) begin
            regs[ridx] <= wdata;
        end
    end

    // Stage 1 captures on the request edge; data stays zero in idle stages so
    // the output needs no gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd;
            dat_pipe[1] <= rd ? regs[ridx] : '0;
            for (int s = 2; s <= RD_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign rd_valid = vld_pipe[RD_LATENCY];
    assign rd_data  = dat_pipe[RD_LATENCY];
endmodule

module cgra_cfg_rf #(
    parameter int NUM_GLB_TILES           = 16,
    parameter int CGRA_PER_GLB            = 2,
    parameter int CGRA_CFG_ADDR_WIDTH     = 32,
    parameter int CGRA_CFG_DATA_WIDTH     = 32,
    parameter int CGRA_CFG_TILE_ID_WIDTH  = 8,
    parameter int CGRA_CFG_REG_ADDR_WIDTH = 8,
    parameter int RD_LATENCY              = 1
) (
    input  logic                                                      clk,
    input  logic                                                      rst_n,
    input  logic [NUM_GLB_TILES-1:0]                                  cgra_cfg_wr_en,
    input  logic [NUM_GLB_TILES-1:0]                                  cgra_cfg_rd_en,
    input  logic [NUM_GLB_TILES-1:0][CGRA_CFG_ADDR_WIDTH-1:0]         cgra_cfg_addr,
    input  logic [NUM_GLB_TILES-1:0][CGRA_CFG_DATA_WIDTH-1:0]         cgra_cfg_data,
    output logic [NUM_GLB_TILES-1:0][CGRA_PER_GLB-1:0][CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_f2g_rd_data,
    output logic [NUM_GLB_TILES-1:0][CGRA_PER_GLB-1:0]                cgra_cfg_f2g_rd_data_valid,
    output logic [NUM_GLB_TILES-1:0]                                  cfg_collision
);
    localparam int TID = CGRA_CFG_TILE_ID_WIDTH;
    localparam int RAW = CGRA_CFG_REG_ADDR_WIDTH;

    if (TID + RAW > CGRA_CFG_ADDR_WIDTH) begin : g_bad_addr_width
        $error("cgra_cfg_rf: tile id + register index wider than address");
    end
    if (NUM_GLB_TILES * CGRA_PER_GLB >= (1 << TID) - 1) begin : g_bad_tile_count
        $error("cgra_cfg_rf: tile count collides with the all-ones tile id");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("cgra_cfg_rf: RD_LATENCY must be 1..4");
    end

    // Address bits above the register index are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cgra_cfg_addr;

    for (genvar i = 0; i < NUM_GLB_TILES; i++) begin : g_chan
        logic [TID-1:0] tid;
        logic [RAW-1:0] ridx;
        logic           bcast;
        logic           rd_clean;

        assign tid      = cgra_cfg_addr[i][TID-1:0];
        assign ridx     = cgra_cfg_addr[i][TID+RAW-1:TID];
        assign rd_clean = cgra_cfg_rd_en[i] & ~cgra_cfg_wr_en[i];
`ifdef CGRA_CFG_RF_BCAST_EN
        assign bcast = &tid;
`else
        assign bcast = 1'b0;
`endif

        for (genvar j = 0; j < CGRA_PER_GLB; j++) begin : g_tile
            localparam int G = i * CGRA_PER_GLB + j;
            logic hit;
            assign hit = (tid == TID'(G));

            cgra_cfg_rf_tile #(
                .DATA_WIDTH     (CGRA_CFG_DATA_WIDTH),
                .REG_ADDR_WIDTH (RAW),
                .RD_LATENCY     (RD_LATENCY)
            ) u_tile (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr       (cgra_cfg_wr_en[i] & (hit | bcast)),
                .rd       (rd_clean & hit),
                .ridx     (ridx),
                .wdata    (cgra_cfg_data[i]),
                .rd_data  (cgra_cfg_f2g_rd_data[i][j]),
                .rd_valid (cgra_cfg_f2g_rd_data_valid[i][j])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_collision <= '0;
        else        cfg_collision <= cfg_collision | (cgra_cfg_wr_en & cgra_cfg_rd_en);
    end
endmodule

// File: tb/tb_cgra_cfg_rf.sv
// Bench for cgra_cfg_rf: three instances (RD_LATENCY 1, 2, 4) on shared stimulus, checked
// against a register-array / pending-read-queue reference model.
module tb_cgra_cfg_rf;
    localparam int NT    = 8;
    localparam int CPG   = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TIDW  = 8;
    localparam int RAW   = 8;
    localparam int NTILE = NT * CPG;
    localparam int NDUT  = 3;
    localparam int LAT [NDUT] = '{1, 2, 4};
`ifdef CGRA_CFG_RF_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [NT-1:0]         wr_en, rd_en;
    logic [NT-1:0][AW-1:0] addr;
    logic [NT-1:0][DW-1:0] data;
    logic [NT-1:0][CPG-1:0][DW-1:0] rdat [NDUT];
    logic [NT-1:0][CPG-1:0]         vld  [NDUT];
    logic [NT-1:0]                  coll [NDUT];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        cgra_cfg_rf #(
            .NUM_GLB_TILES(NT), .CGRA_PER_GLB(CPG), .CGRA_CFG_ADDR_WIDTH(AW),
            .CGRA_CFG_DATA_WIDTH(DW), .CGRA_CFG_TILE_ID_WIDTH(TIDW),
            .CGRA_CFG_REG_ADDR_WIDTH(RAW), .RD_LATENCY(LAT[k])
        ) u_dut (
            .clk                        (clk),
            .rst_n                      (rst_n),
            .cgra_cfg_wr_en             (wr_en),
            .cgra_cfg_rd_en             (rd_en),
            .cgra_cfg_addr              (addr),
            .cgra_cfg_data              (data),
            .cgra_cfg_f2g_rd_data       (rdat[k]),
            .cgra_cfg_f2g_rd_data_valid (vld[k]),
            .cfg_collision              (coll[k])
        );
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            k;
        int            g;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] mreg [NTILE][1 << RAW];
    logic [NT-1:0] mcoll;
    rd_t           pend [$];
    logic [NT-1:0][CPG-1:0]         exp_vld [NDUT];
    logic [NT-1:0][CPG-1:0][DW-1:0] exp_dat [NDUT];
    int cyc, n_cmp, n_err;

    task automatic model_clear();
        for (int g = 0; g < NTILE; g++)
            for (int r = 0; r < (1 << RAW); r++) mreg[g][r] = '0;
        pend.delete();
        mcoll = '0;
        for (int k = 0; k < NDUT; k++) begin
            exp_vld[k] = '0;
            exp_dat[k] = '0;
        end
    endtask

    // One clock: apply the model's view of the edge, then settle expectations at the negedge.
    task automatic tick();
        rd_t keep [$];
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            for (int i = 0; i < NT; i++) begin
                int tid, r;
                tid = int'(addr[i][TIDW-1:0]);
                r   = int'(addr[i][TIDW+RAW-1:TIDW]);
                if (wr_en[i] && rd_en[i]) mcoll[i] = 1'b1;
                if (rd_en[i] && !wr_en[i] && tid / CPG == i) begin
                    for (int k = 0; k < NDUT; k++) begin
                        rd_t e;
                        e.due = cyc + LAT[k] - 1;
                        e.k   = k;
                        e.g   = tid;
                        e.d   = mreg[tid][r];
                        pend.push_back(e);
                    end
                end
                if (wr_en[i]) begin
                    if (tid / CPG == i) mreg[tid][r] = data[i];
                    else if (BCAST && tid == (1 << TIDW) - 1)
                        for (int j = 0; j < CPG; j++) mreg[i*CPG + j][r] = data[i];
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            exp_vld[k] = '0;
            exp_dat[k] = '0;
        end
        foreach (pend[n]) begin
            if (pend[n].due == cyc) begin
                exp_vld[pend[n].k][pend[n].g / CPG][pend[n].g % CPG] = 1'b1;
                exp_dat[pend[n].k][pend[n].g / CPG][pend[n].g % CPG] = pend[n].d;
            end
            if (pend[n].due > cyc) keep.push_back(pend[n]);
        end
        pend = keep;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_ops();
        wr_en = '0;
        rd_en = '0;
        addr  = '0;
        data  = '0;
    endtask

    task automatic set_op(input int ch, input bit w, input bit r, input int tid,
                          input int ridx, input logic [DW-1:0] d);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[TIDW-1:0]        = TIDW'(tid);
        a[TIDW+RAW-1:TIDW] = RAW'(ridx);
        addr[ch]  = a;
        wr_en[ch] = w;
        rd_en[ch] = r;
        data[ch]  = d;
    endtask

    task automatic assert_reset();
        #2 rst_n = 1'b0;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int seen, seen_cyc, rd_cyc;
        logic [DW-1:0] got;
        seen = 0; seen_cyc = -1; rd_cyc = -100; got = 'x;
        for (int t = 0; t < 8; t++) begin
            clear_ops();
            if (t == 0) begin
                assert_reset();
                #1;
                for (int k = 0; k < NDUT; k++) begin
                    n_cmp++;
                    if (vld[k] !== '0 || rdat[k] !== '0 || coll[k] !== '0) begin
                        n_err++;
                        $display("FAIL reset_state L%0d: vld=%h coll=%h, want all zero", LAT[k], vld[k], coll[k]);
                    end
                end
            end
            if (t == 2) rst_n = 1'b1;
            if (t == 3) set_op(1, 1'b0, 1'b1, 3, 8'h10, '0);
            tick();
            if (t == 3) rd_cyc = cyc;
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (vld[k] !== exp_vld[k] || rdat[k] !== exp_dat[k] || coll[k] !== mcoll) begin
                    n_err++;
                    $display("FAIL reset_read L%0d cyc%0d: vld=%h coll=%h data=%h, want vld=%h coll=%h data=%h",
                             LAT[k], cyc, vld[k], coll[k], rdat[k], exp_vld[k], mcoll, exp_dat[k]);
                end
            end
            if (vld[1][1][1] === 1'b1) begin
                seen++;
                seen_cyc = cyc;
                got = rdat[1][1][1];
            end
        end
        n_cmp++;
        if (seen !== 1 || seen_cyc !== rd_cyc + 1 || got !== 32'h0) begin
            n_err++;
            $display("FAIL reset_read_l2: valids=%0d at cyc %0d data=%h, want 1 at cyc %0d data=0",
                     seen, seen_cyc, got, rd_cyc + 1);
        end
    endtask

    task automatic test_write_readback();
        int seen, stray;
        logic [DW-1:0] got;
        seen = 0; stray = 0; got = 'x;
        for (int t = 0; t < 8; t++) begin
            clear_ops();
            if (t == 0) set_op(2, 1'b1, 1'b0, 5, 8'h7F, 32'hDEADBEEF);
            if (t == 1) begin
                set_op(2, 1'b0, 1'b1, 5, 8'h7F, '0);
                set_op(0, 1'b0, 1'b1, 5, 8'h7F, '0);
            end
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (vld[k] !== exp_vld[k] || rdat[k] !== exp_dat[k] || coll[k] !== mcoll) begin
                    n_err++;
                    $display("FAIL write_readback L%0d cyc%0d: vld=%h coll=%h data=%h, want vld=%h coll=%h data=%h",
                             LAT[k], cyc, vld[k], coll[k], rdat[k], exp_vld[k], mcoll, exp_dat[k]);
                end
                if (vld[k][0] !== '0) stray++;
            end
            if (vld[1][2][1] === 1'b1) begin
                seen++;
                got = rdat[1][2][1];
            end
        end
        n_cmp++;
        if (seen !== 1 || got !== 32'hDEADBEEF || stray !== 0) begin
            n_err++;
            $display("FAIL write_readback_l2: valids=%0d data=%h ch0_valids=%0d, want 1 DEADBEEF 0",
                     seen, got, stray);
        end
    endtask

    task automatic test_back_to_back();
        int first, last, n;
        logic [DW-1:0] seq [4];
        first = -1; last = -1; n = 0;
        for (int t = 0; t < 14; t++) begin
            clear_ops();
            if (t < 4) set_op(0, 1'b1, 1'b0, 0, t, 32'h100 + t);
            else if (t < 8) set_op(0, 1'b0, 1'b1, 0, t - 4, '0);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (vld[k] !== exp_vld[k] || rdat[k] !== exp_dat[k] || coll[k] !== mcoll) begin
                    n_err++;
                    $display("FAIL back_to_back L%0d cyc%0d: vld=%h coll=%h data=%h, want vld=%h coll=%h data=%h",
                             LAT[k], cyc, vld[k], coll[k], rdat[k], exp_vld[k], mcoll, exp_dat[k]);
                end
            end
            if (vld[2][0][0] === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (n < 4) seq[n] = rdat[2][0][0];
                n++;
            end
        end
        n_cmp++;
        if (n !== 4 || last - first !== 3) begin
            n_err++;
            $display("FAIL back_to_back_l4_span: valids=%0d span=%0d, want 4 and 3", n, last - first);
        end
        for (int m = 0; m < 4 && m < n; m++) begin
            n_cmp++;
            if (seq[m] !== 32'h100 + m) begin
                n_err++;
                $display("FAIL back_to_back_l4_order[%0d]: got %h, want %h", m, seq[m], 32'h100 + m);
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] got;
        int seen;
        got = 'x; seen = 0;
        for (int t = 0; t < 12; t++) begin
            clear_ops();
            if (t == 0) set_op(4, 1'b1, 1'b1, 8, 8'h20, 32'h55);
            if (t == 5) set_op(4, 1'b0, 1'b1, 8, 8'h20, '0);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (vld[k] !== exp_vld[k] || rdat[k] !== exp_dat[k] || coll[k] !== mcoll) begin
                    n_err++;
                    $display("FAIL collision L%0d cyc%0d: vld=%h coll=%h data=%h, want vld=%h coll=%h data=%h",
                             LAT[k], cyc, vld[k], coll[k], rdat[k], exp_vld[k], mcoll, exp_dat[k]);
                end
            end
            if (vld[0][4][0] === 1'b1) begin
                seen++;
                got = rdat[0][4][0];
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            n_cmp++;
            if (coll[k][4] !== 1'b1) begin
                n_err++;
                $display("FAIL collision_sticky L%0d: flag=%b, want 1", LAT[k], coll[k][4]);
            end
        end
        n_cmp++;
        if (seen !== 1 || got !== 32'h55) begin
            n_err++;
            $display("FAIL collision_readback_l1: valids=%0d data=%h, want 1 and 55", seen, got);
        end
    endtask

    task automatic test_reset_mid_read();
        int pre_seen, post_seen;
        logic [DW-1:0] got;
        pre_seen = 0; post_seen = 0; got = 'x;
        for (int t = 0; t < 13; t++) begin
            clear_ops();
            if (t == 0) set_op(0, 1'b1, 1'b0, 1, 3, 32'h1234);
            if (t == 1) set_op(0, 1'b0, 1'b1, 1, 3, '0);
            if (t == 3) begin
                assert_reset();
                #1;
                for (int k = 0; k < NDUT; k++) begin
                    n_cmp++;
                    if (vld[k] !== '0 || rdat[k] !== '0 || coll[k] !== '0) begin
                        n_err++;
                        $display("FAIL reset_async L%0d: vld=%h coll=%h data=%h, want all zero",
                                 LAT[k], vld[k], coll[k], rdat[k]);
                    end
                end
            end
            if (t == 5) rst_n = 1'b1;
            if (t == 6) set_op(0, 1'b0, 1'b1, 1, 3, '0);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (vld[k] !== exp_vld[k] || rdat[k] !== exp_dat[k] || coll[k] !== mcoll) begin
                    n_err++;
                    $display("FAIL reset_mid_read L%0d cyc%0d: vld=%h coll=%h data=%h, want vld=%h coll=%h data=%h",
                             LAT[k], cyc, vld[k], coll[k], rdat[k], exp_vld[k], mcoll, exp_dat[k]);
                end
            end
            if (vld[2][0][1] === 1'b1) begin
                if (t < 6) pre_seen++;
                else begin
                    post_seen++;
                    got = rdat[2][0][1];
                end
            end
        end
        n_cmp++;
        if (pre_seen !== 0 || post_seen !== 1 || got !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_read_l4: pre=%0d post=%0d data=%h, want 0 1 0", pre_seen, post_seen, got);
        end
    endtask

    task automatic test_bcast();
        logic [DW-1:0] got6, got7, got4, got5;
        got6 = 'x; got7 = 'x; got4 = 'x; got5 = 'x;
        for (int t = 0; t < 9; t++) begin
            clear_ops();
            if (t == 0) set_op(3, 1'b1, 1'b0, 255, 1, 32'hA5A5);
            if (t == 1) begin
                set_op(3, 1'b0, 1'b1, 6, 1, '0);
                set_op(2, 1'b0, 1'b1, 4, 1, '0);
            end
            if (t == 2) begin
                set_op(3, 1'b0, 1'b1, 7, 1, '0);
                set_op(2, 1'b0, 1'b1, 5, 1, '0);
            end
            if (t == 3) set_op(3, 1'b0, 1'b1, 255, 1, '0);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (vld[k] !== exp_vld[k] || rdat[k] !== exp_dat[k] || coll[k] !== mcoll) begin
                    n_err++;
                    $display("FAIL bcast L%0d cyc%0d: vld=%h coll=%h data=%h, want vld=%h coll=%h data=%h",
                             LAT[k], cyc, vld[k], coll[k], rdat[k], exp_vld[k], mcoll, exp_dat[k]);
                end
            end
            if (vld[0][3][0] === 1'b1) got6 = rdat[0][3][0];
            if (vld[0][3][1] === 1'b1) got7 = rdat[0][3][1];
            if (vld[0][2][0] === 1'b1) got4 = rdat[0][2][0];
            if (vld[0][2][1] === 1'b1) got5 = rdat[0][2][1];
        end
        n_cmp++;
        if (got6 !== (BCAST ? 32'hA5A5 : 32'h0) || got7 !== (BCAST ? 32'hA5A5 : 32'h0)
            || got4 !== 32'h0 || got5 !== 32'h0) begin
            n_err++;
            $display("FAIL bcast_tiles: t4=%h t5=%h t6=%h t7=%h, want 0 0 %h %h",
                     got4, got5, got6, got7, BCAST ? 32'hA5A5 : 32'h0, BCAST ? 32'hA5A5 : 32'h0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 320; t++) begin
            clear_ops();
            for (int i = 0; i < NT; i++) begin
                int sel, tid;
                sel = $urandom_range(0, 8);
                if (sel <= 5)      tid = i * CPG + $urandom_range(0, CPG - 1);
                else if (sel == 6) tid = ((i + 1) % NT) * CPG;
                else if (sel == 7) tid = 255;
                else               tid = $urandom_range(0, 255);
                set_op(i, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, tid,
                       $urandom_range(0, 3), $urandom);
            end
            if (t == 150) assert_reset();
            if (t == 152) rst_n = 1'b1;
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (vld[k] !== exp_vld[k] || rdat[k] !== exp_dat[k] || coll[k] !== mcoll) begin
                    n_err++;
                    $display("FAIL random L%0d cyc%0d: vld=%h coll=%h data=%h, want vld=%h coll=%h data=%h",
                             LAT[k], cyc, vld[k], coll[k], rdat[k], exp_vld[k], mcoll, exp_dat[k]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        clear_ops();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_readback();
        test_back_to_back();
        test_collision();
        test_reset_mid_read();
        test_bcast();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cgra_cfg_rf.md
# cgra_cfg_rf

Parametrised behavioural model of the CGRA-side configuration register file, driven by the global buffer's per-tile configuration channels. Each GLB tile owns one channel feeding `CGRA_PER_GLB` CGRA tiles, and each CGRA tile holds `2^CGRA_CFG_REG_ADDR_WIDTH` registers. The block decodes per-channel writes and reads, and returns read data with a fixed, parametrised latency on per-CGRA-tile `f2g` read ports. It is the simulation target for GLB configuration-path tests, including read-back.

## Interface
Parameters:
- `NUM_GLB_TILES`, 16: number of configuration channels.
- `CGRA_PER_GLB`, 2: CGRA tiles per channel; global tile id `g = i*CGRA_PER_GLB + j`.
- `CGRA_CFG_ADDR_WIDTH`, 32: address width.
- `CGRA_CFG_DATA_WIDTH`, 32: data width.
- `CGRA_CFG_TILE_ID_WIDTH`, 8: tile id field `addr[TID-1:0]`.
- `CGRA_CFG_REG_ADDR_WIDTH`, 8: register index field `addr[TID+RAW-1:TID]`.
- `RD_LATENCY`, 1: read latency, legal range 1..4.
- Elaboration-time checks:
  - `TID + RAW <= CGRA_CFG_ADDR_WIDTH`.
  - `NUM_GLB_TILES*CGRA_PER_GLB < 2^TID - 1`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cgra_cfg_wr_en`  in  `[NUM_GLB_TILES]`  per-channel write strobe.
- `cgra_cfg_rd_en`  in  `[NUM_GLB_TILES]`  per-channel read strobe.
- `cgra_cfg_addr`  in  `[NUM_GLB_TILES][CGRA_CFG_ADDR_WIDTH]`  per-channel address.
- `cgra_cfg_data`  in  `[NUM_GLB_TILES][CGRA_CFG_DATA_WIDTH]`  per-channel write data.
- `cgra_cfg_f2g_rd_data`  out  `[NUM_GLB_TILES][CGRA_PER_GLB][CGRA_CFG_DATA_WIDTH]`  read data.
- `cgra_cfg_f2g_rd_data_valid`  out  `[NUM_GLB_TILES][CGRA_PER_GLB]`  read data valid.
- `cfg_collision`  out  `[NUM_GLB_TILES]`  sticky flag: write and read were asserted together on the channel.

## Operation
- Address decode per channel `i`:
  - `tid = addr[TID-1:0]`.
  - `ridx = addr[TID+RAW-1:TID]`.
  - Upper address bits are ignored.
- A tile `g` matches only if `tid == g` and `g` belongs to channel `i`. A `tid` that belongs to another channel's tiles, or to no tile, is a no-op.
- Write: when `wr_en[i]` is high and the address matches, `reg[g][ridx] <= data[i]` at the posedge.
- Read: when `rd_en[i]` is high, `wr_en[i]` is low, and the address matches:
  - `reg[g][ridx]` is sampled at the posedge and pushed into tile `g`'s read pipeline.
  - It appears on `f2g_rd_data[i][j]` with valid high exactly `RD_LATENCY` cycles later, for one cycle.
- Collision (`wr_en[i]` and `rd_en[i]` both high):
  - The write is performed.
  - The read is dropped; no valid is ever produced for it.
  - `cfg_collision[i]` sets and holds until reset.
- Read pipeline: one stage per cycle of latency, per CGRA tile, fully pipelined. Back-to-back reads on consecutive cycles produce valid on consecutive cycles; there is no stall and no backpressure.
- While valid is low, `f2g_rd_data` is driven to 0.
- Channels are fully independent; all channels may be active in the same cycle.

## Timing
- Reset (`rst_n` low, asynchronous):
  - All registers are cleared to 0.
  - All pipeline stages are cleared; `rd_data` and `rd_data_valid` go to 0 immediately.
  - `cfg_collision` goes to 0.
  - A read in flight when reset asserts is discarded and never returns.
- Read-after-write to the same register:
  - Write at edge N, read at edge N+1: the read returns the new value.
  - Write and read at the same edge: this is a collision, as defined above.
- Write latency is 0 cycles: the value is visible to a read at the next edge.
- Read latency: sample at edge N; valid is high during the cycle after edge `N+RD_LATENCY-1`, i.e. registered out at edge `N+RD_LATENCY-1` for `RD_LATENCY=1`, the same edge as the sample.
- `ridx` wraps naturally within `RAW` bits; there is no out-of-range case.

## Configuration
- Macro: `CGRA_CFG_RF_BCAST_EN`.
- When defined: a write on channel `i` with `tid` all-ones (`2^TID-1`) updates `reg[g][ridx]` for every tile `g` of channel `i` in the same cycle.
  - A read with the broadcast `tid` returns nothing.
  - A collision involving a broadcast address still sets `cfg_collision[i]`.
- When undefined: the all-ones `tid` matches no tile; writes and reads to it are no-ops (a simultaneous `wr_en`/`rd_en` still sets the flag).

## Test plan
- Reset then read: with `RD_LATENCY=2`, read `tid=3`, `ridx=0x10` -> `f2g_rd_data[1][1]=0` with valid high 2 cycles later; every other valid stays 0.
- Write then read back: write `0xDEADBEEF` to `tid=5`, `ridx=0x7F` on channel 2, then read the next cycle -> `0xDEADBEEF` on `[2][1]` after `RD_LATENCY`. A read of `tid=5` on channel 0 -> no valid.
- Back-to-back reads: four consecutive reads on channel 0 of `ridx` 0..3 previously written `0x100..0x103` -> four consecutive valid cycles, data in order, no gaps.
- Collision: on channel 4, `wr_en=rd_en=1`, `tid=8`, data `0x55` -> the register holds `0x55`, no valid appears, `cfg_collision[4]=1` and it stays 1. A later clean read returns `0x55`.
- Reset mid-read: issue a read with `RD_LATENCY=4`, pulse `rst_n` low 2 cycles later -> valid never asserts; the register reads 0 after reset.
- With `CGRA_CFG_RF_BCAST_EN`: write `0xA5A5` with `tid=0xFF`, `ridx=1` on channel 3 -> both tiles 6 and 7 read back `0xA5A5`; tiles 4 and 5 are unchanged. With the macro undefined, the same write leaves all tiles at 0.
